gift_slayer_serial_3sh: RTL and testbench

Nibble-serial substitution layer for a 3-share, second-order masked GIFT-64 datapath. It accepts a full 64-bit state as three Boolean shares and streams its 16 nibbles, one per cycle, through a single 3-share GIFT S-box core (`GIFTG_2order_NoFresh`: one registered stage, no fresh randomness). It reassembles the 16 masked S-box outputs into a 64-bit 3-share state. It sits between the round key-addition stage (upstream) and the bit-permutation stage (downstream) of the masked round.

---
 rtl/gift_slayer_serial_3sh_if.sv | 24 ++
 rtl/gift_slayer_serial_3sh.sv | 166 ++++++++++++++++
 tb/tb_gift_slayer_serial_3sh.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/gift_slayer_serial_3sh_if.sv
// Handshake and share bus of the nibble-serial 3-share GIFT-64 substitution layer.
interface gift_slayer_serial_3sh_if #(
    parameter int unsigned NIB = 16
);
    logic             start;
    logic [4*NIB-1:0] in1;
    logic [4*NIB-1:0] in2;
    logic [4*NIB-1:0] in3;
    logic             busy;
    logic             done;
    logic [4*NIB-1:0] out1;
    logic [4*NIB-1:0] out2;
    logic [4*NIB-1:0] out3;

    modport master (
        output start, in1, in2, in3,
        input  busy, done, out1, out2, out3
    );

    modport slave (
        input  start, in1, in2, in3,
        output busy, done, out1, out2, out3
    );
endinterface

// File: rtl/gift_slayer_serial_3sh.sv
// Nibble-serial substitution layer for 3-share masked GIFT-64: one shared S-box core, 18-cycle layer.
// Optional macro SLAYER_CLEAR_EN clears outputs on start and gates core inputs outside feed cycles.
module gift_slayer_serial_3sh #(
    parameter int unsigned NIB = 16
) (
    input logic                     clk,
    input logic                     rst,
    gift_slayer_serial_3sh_if.slave bus
);
    localparam int unsigned W    = 4 * NIB;
    localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;
    logic [W-1:0]    sr1_q, sr2_q, sr3_q;
    logic [W-1:0]    out1_q, out2_q, out3_q;

    logic [3:0]      core_in1, core_in2, core_in3;
    logic [3:0]      core_out1_d, core_out2_d, core_out3_d;
    logic [3:0]      core_out1_q, core_out2_q, core_out3_q;
    logic [2:0]      x_sh [4];
    logic [2:0]      y_sh [4];

    // Output share that absorbs a cross-share product: the first share index the term does not
    // touch, so no single output share sees all inputs of a term whenever that is possible.
    function automatic logic [2:0] dest(input logic [2:0] used, input logic [2:0] tie);
        if (!used[0]) return 3'b001;
        if (!used[1]) return 3'b010;
        if (!used[2]) return 3'b100;
        return tie;
    endfunction

    // Masked AND of two bits; bit s of each operand is its share s.
    function automatic logic [2:0] and2(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] r;
        r = '0;
        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < 3; t++) begin
                r = r ^ (dest((3'b001 << s) | (3'b001 << t), 3'b001) & {3{a[s] & b[t]}});
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] and3(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] c);
        logic [2:0] r;
        r = '0;
        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < 3; t++) begin
                for (int u = 0; u < 3; u++) begin
                    r = r ^ (dest((3'b001 << s) | (3'b001 << t) | (3'b001 << u), 3'b001 << s)
                             & {3{a[s] & b[t] & c[u]}});
                end
            end
        end
        return r;
    endfunction

`ifdef SLAYER_CLEAR_EN
    assign core_in1 = (state_q == StFeed) ? sr1_q[3:0] : 4'h0;
    assign core_in2 = (state_q == StFeed) ? sr2_q[3:0] : 4'h0;
    assign core_in3 = (state_q == StFeed) ? sr3_q[3:0] : 4'h0;
`else
    assign core_in1 = sr1_q[3:0];
    assign core_in2 = sr2_q[3:0];
    assign core_in3 = sr3_q[3:0];
`endif

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            x_sh[b] = {core_in3[b], core_in2[b], core_in1[b]};
        end
    end

    // GIFT S-box in algebraic normal form, evaluated share-wise; the constant lands on share 1.
    assign y_sh[0] = 3'b001 ^ x_sh[0] ^ x_sh[1] ^ x_sh[2] ^ x_sh[3] ^ and2(x_sh[0], x_sh[1]);
    assign y_sh[1] = x_sh[0] ^ x_sh[2] ^ x_sh[3] ^ and2(x_sh[0], x_sh[1])
                     ^ and2(x_sh[0], x_sh[2]);
    assign y_sh[2] = x_sh[1] ^ x_sh[2] ^ and2(x_sh[0], x_sh[3]) ^ and2(x_sh[1], x_sh[3])
                     ^ and3(x_sh[1], x_sh[2], x_sh[3]);
    assign y_sh[3] = x_sh[0] ^ and2(x_sh[1], x_sh[3]) ^ and3(x_sh[0], x_sh[2], x_sh[3]);

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            core_out1_d[b] = y_sh[b][0];
            core_out2_d[b] = y_sh[b][1];
            core_out3_d[b] = y_sh[b][2];
        end
    end

    // Core pipeline register carries no reset; valid_q qualifies its contents.
    always_ff @(posedge clk) begin
        core_out1_q <= core_out1_d;
        core_out2_q <= core_out2_d;
        core_out3_q <= core_out3_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sr1_q   <= '0;
            sr2_q   <= '0;
            sr3_q   <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            out3_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= (state_q == StFeed);
            if (valid_q) begin
                out1_q <= {core_out1_q, out1_q[W-1:4]};
                out2_q <= {core_out2_q, out2_q[W-1:4]};
                out3_q <= {core_out3_q, out3_q[W-1:4]};
            end
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StFeed;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        sr1_q   <= bus.in1;
                        sr2_q   <= bus.in2;
                        sr3_q   <= bus.in3;
`ifdef SLAYER_CLEAR_EN
                        out1_q  <= '0;
                        out2_q  <= '0;
                        out3_q  <= '0;
`endif
                    end
                end
                StFeed: begin
                    sr1_q <= {4'h0, sr1_q[W-1:4]};
                    sr2_q <= {4'h0, sr2_q[W-1:4]};
                    sr3_q <= {4'h0, sr3_q[W-1:4]};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.out1 = out1_q;
    assign bus.out2 = out2_q;
    assign bus.out3 = out3_q;
endmodule

// File: tb/tb_gift_slayer_serial_3sh.sv
// Directed bench for the 3-share nibble-serial GIFT S-layer: latency, busy guard, reset, masking.
module tb_gift_slayer_serial_3sh;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [63:0] prev_exp;

    gift_slayer_serial_3sh_if #(.NIB(16)) bus ();

    gift_slayer_serial_3sh #(.NIB(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] slayer_ref(input logic [63:0] x);
        logic [63:0] tbl;
        logic [63:0] r;
        tbl = 64'hE805_7BD2_93F6_C4A1;
        r   = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = tbl[4*int'(x[4*n +: 4]) +: 4];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle T (after the edge); returns in the done cycle, or one cycle later if tail.
    task automatic run_check(input string tag, input logic [63:0] x, input logic [63:0] m2,
                             input logic [63:0] m3, input logic [63:0] exp, input int glitch_at,
                             input logic [63:0] gx, input bit tail);
        int idx;
        int busy_hi;
        logic [63:0] res;
        bus.in1   = x ^ m2 ^ m3;
        bus.in2   = m2;
        bus.in3   = m3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
`ifdef SLAYER_CLEAR_EN
        check({tag, "_clr"}, bus.out1 | bus.out2 | bus.out3, 64'h0);
`else
        check({tag, "_hold"}, bus.out1 ^ bus.out2 ^ bus.out3, prev_exp);
`endif
        idx     = 1;
        busy_hi = 0;
        while (idx < 40) begin
            if (bus.done) break;
            if (bus.busy) busy_hi++;
            if (idx == glitch_at) begin
                bus.start = 1'b1;
                bus.in1   = gx;
                bus.in2   = ~gx;
                bus.in3   = 64'h5A5A_5A5A_5A5A_5A5A;
            end else begin
                bus.start = 1'b0;
            end
            step();
            idx++;
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, 64'(idx), 64'd18);
        check({tag, "_busyhi"}, 64'(busy_hi), 64'd17);
        check({tag, "_busydone"}, {63'd0, bus.busy}, 64'd0);
        res = bus.out1 ^ bus.out2 ^ bus.out3;
        check({tag, "_res"}, res, exp);
        prev_exp = exp;
        if (tail) begin
            step();
            check({tag, "_pulse"}, {63'd0, bus.done}, 64'd0);
            check({tag, "_stable"}, bus.out1 ^ bus.out2 ^ bus.out3, exp);
`ifdef SLAYER_CLEAR_EN
            check({tag, "_coreidle"}, {52'd0, dut.core_in1, dut.core_in2, dut.core_in3}, 64'd0);
`endif
        end
    endtask

    initial begin
        int done_seen;
        logic [63:0] x, m2, m3;
        total     = 0;
        bad       = 0;
        prev_exp  = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.in3   = '0;
        step();
        step();
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_outs", bus.out1 | bus.out2 | bus.out3, 64'd0);
        rst = 1'b0;
        step();

        run_check("plain", 64'h0123_4567_89AB_CDEF, 64'h0, 64'h0,
                  64'h1A4C_6F39_2DB7_508E, 0, 64'h0, 1'b1);
        run_check("zero", 64'h0, 64'h0, 64'h0, 64'h1111_1111_1111_1111, 0, 64'h0, 1'b1);
        run_check("ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hDEAD_BEEF_0BAD_F00D,
                  64'h1357_9BDF_2468_ACE0, 64'hEEEE_EEEE_EEEE_EEEE, 0, 64'h0, 1'b1);
        run_check("desc", 64'hFEDC_BA98_7654_3210, 64'hA5A5_0F0F_3C3C_9696,
                  64'h0123_0123_FFFF_8001, 64'hE805_7BD2_93F6_C4A1, 0, 64'h0, 1'b1);
        run_check("mask", 64'h0123_4567_89AB_CDEF, 64'h8BAD_F00D_CAFE_BABE,
                  64'h7777_0000_1234_FEDC, 64'h1A4C_6F39_2DB7_508E, 0, 64'h0, 1'b1);

        // Busy guard: different shares offered in cycle T+5 must be ignored.
        run_check("guard", 64'hFEDC_BA98_7654_3210, 64'h1111_2222_3333_4444,
                  64'h9999_AAAA_BBBB_CCCC, 64'hE805_7BD2_93F6_C4A1, 5, 64'h0123_4567_89AB_CDEF,
                  1'b1);

        // Back-to-back: second start issued in the first done cycle.
        run_check("b2b_a", 64'h0123_4567_89AB_CDEF, 64'h0F1E_2D3C_4B5A_6978,
                  64'hFFFF_0000_FFFF_0000, 64'h1A4C_6F39_2DB7_508E, 0, 64'h0, 1'b0);
        run_check("b2b_b", 64'h0, 64'h3141_5926_5358_9793, 64'h2718_2818_2845_9045,
                  64'h1111_1111_1111_1111, 0, 64'h0, 1'b1);

        // Reset in cycle T+8 aborts the layer.
        bus.in1   = 64'h0123_4567_89AB_CDEF;
        bus.in2   = 64'h0;
        bus.in3   = 64'h0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_busy", {63'd0, bus.busy}, 64'd0);
        check("mid_done", {63'd0, bus.done}, 64'd0);
        check("mid_outs", bus.out1 | bus.out2 | bus.out3, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) done_seen++;
            step();
        end
        check("mid_nodone", 64'(done_seen), 64'd0);
        prev_exp = '0;
        run_check("after_rst", 64'hFEDC_BA98_7654_3210, 64'h0, 64'h6666_6666_6666_6666,
                  64'hE805_7BD2_93F6_C4A1, 0, 64'h0, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            x  = {$urandom, $urandom};
            m2 = {$urandom, $urandom};
            m3 = {$urandom, $urandom};
            run_check("rnd", x, m2, m3, slayer_ref(x), 0, 64'h0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
